fact_scheduler: RTL and testbench

Memory-mapped job scheduler that sits between the MIPS data bus and the factorial accelerator. The CPU queues operands in a job FIFO. An internal FSM then acts as the accelerator's only bus master: it loads each operand, starts the accelerator, polls for completion and captures the result into a result FIFO. The CPU drains results at its own pace. The block occupies the accelerator's address window in the SoC address decoder; the accelerator is reachable only through it.

---
 rtl/fact_sched_pkg.sv | 35 +++
 rtl/fact_scheduler_if.sv | 14 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/fact_scheduler.sv | 145 ++++++++++++++
 tb/tb_fact_scheduler.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fact_sched_pkg.sv
// rtl/fact_sched_pkg.sv - shared states, address offsets and register bit positions
package fact_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GO,
    ST_WAIT,
    ST_CAPT
  } state_e;

  localparam logic [1:0] CPU_JOB    = 2'd0;
  localparam logic [1:0] CPU_RES    = 2'd1;
  localparam logic [1:0] CPU_STATUS = 2'd2;
  localparam logic [1:0] CPU_CTRL   = 2'd3;

  localparam logic [1:0] FA_N    = 2'd0;
  localparam logic [1:0] FA_GO   = 2'd1;
  localparam logic [1:0] FA_STAT = 2'd2;
  localparam logic [1:0] FA_RES  = 2'd3;

  localparam int FA_DONE_BIT = 0;
  localparam int FA_ERR_BIT  = 1;

  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_OVF_BIT    = 1;
  localparam int STAT_HERR_BIT   = 2;
  localparam int STAT_REMPTY_BIT = 3;
  localparam int STAT_JCNT_LSB   = 4;
  localparam int STAT_RCNT_LSB   = 8;

  localparam int CTRL_CLR_OVF_BIT = 0;
  localparam int CTRL_FLUSH_BIT   = 1;

endpackage

// File: rtl/fact_scheduler_if.sv
// rtl/fact_scheduler_if.sv - CPU-side and accelerator-side bus signals of the scheduler
interface fact_scheduler_if;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        fa_we;
  logic [1:0]  fa_a;
  logic [3:0]  fa_wd;
  logic [31:0] fa_rd;

  modport slave  (input we, a, wd, fa_rd, output rd, fa_we, fa_a, fa_wd);
  modport master (output we, a, wd, fa_rd, input rd, fa_we, fa_a, fa_wd);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO; push on full and pop on empty are ignored, clear wins
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/fact_scheduler.sv
// rtl/fact_scheduler.sv - CPU job queue in front of the factorial accelerator; sole bus master of it
module fact_scheduler
  import fact_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  fact_scheduler_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;

  logic          cpu_job_wr, cpu_res_wr, cpu_ctrl_wr, flush, clr_ovf;
  logic          job_push, job_pop, job_full, job_empty;
  logic [3:0]    job_head;
  logic [CW-1:0] job_count;
  logic          res_push, res_full, res_empty;
  logic [32:0]   res_head, res_wdata;
  logic [CW-1:0] res_count;
  logic          fa_we, head_err;
  logic [1:0]    fa_a;
  logic [3:0]    fa_wd;
  logic [31:0]   rd_data;

  assign cpu_job_wr  = bus.we && (bus.a == CPU_JOB);
  assign cpu_res_wr  = bus.we && (bus.a == CPU_RES);
  assign cpu_ctrl_wr = bus.we && (bus.a == CPU_CTRL);
  assign flush       = cpu_ctrl_wr && bus.wd[CTRL_FLUSH_BIT];
  assign clr_ovf     = cpu_ctrl_wr && bus.wd[CTRL_CLR_OVF_BIT];
  assign job_push    = cpu_job_wr && !flush;
  assign res_wdata   = {err_q, err_q ? 32'h0 : bus.fa_rd};
  assign head_err    = !res_empty && res_head[32];

  sync_fifo #(.WIDTH(4), .DEPTH(DEPTH)) u_job_fifo (
    .clk(clk), .rst(rst), .clr_i(flush), .push_i(job_push), .wdata_i(bus.wd[3:0]),
    .pop_i(job_pop), .rdata_o(job_head), .full_o(job_full), .empty_o(job_empty),
    .count_o(job_count)
  );

  sync_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_res_fifo (
    .clk(clk), .rst(rst), .clr_i(flush), .push_i(res_push), .wdata_i(res_wdata),
    .pop_i(cpu_res_wr), .rdata_o(res_head), .full_o(res_full), .empty_o(res_empty),
    .count_o(res_count)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (cpu_job_wr && job_full && !flush) ovf_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    job_pop  = 1'b0;
    res_push = 1'b0;
    fa_we    = 1'b0;
    fa_a     = FA_N;
    fa_wd    = 4'h0;
    case (state_q)
      ST_IDLE: if (!job_empty && !res_full) state_d = ST_LOAD;
      ST_LOAD: begin
        fa_we   = 1'b1;
        fa_a    = FA_N;
        fa_wd   = job_head;
        job_pop = 1'b1;
        state_d = ST_GO;
      end
      ST_GO: begin
        fa_we   = 1'b1;
        fa_a    = FA_GO;
        fa_wd   = 4'h1;
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        fa_a = FA_STAT;
        // A done seen on the final allowed cycle still beats the timeout.
        if (bus.fa_rd[FA_DONE_BIT]) begin
          err_d   = bus.fa_rd[FA_ERR_BIT];
          state_d = ST_CAPT;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_CAPT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_CAPT: begin
        fa_a     = FA_RES;
        res_push = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case (bus.a)
      CPU_JOB: rd_data = 32'(job_count);
      CPU_RES: rd_data = res_empty ? 32'h0 : res_head[31:0];
      CPU_STATUS: begin
        rd_data[STAT_BUSY_BIT]         = (state_q != ST_IDLE);
        rd_data[STAT_OVF_BIT]          = ovf_q;
        rd_data[STAT_HERR_BIT]         = head_err;
        rd_data[STAT_REMPTY_BIT]       = res_empty;
        rd_data[STAT_JCNT_LSB +: 4]    = 4'(job_count);
        rd_data[STAT_RCNT_LSB +: 4]    = 4'(res_count);
      end
      default: rd_data = 32'h0;
    endcase
  end

  assign bus.rd    = rd_data;
  assign bus.fa_we = fa_we;
  assign bus.fa_a  = fa_a;
  assign bus.fa_wd = fa_wd;
endmodule

// File: tb/tb_fact_scheduler.sv
// tb/tb_fact_scheduler.sv - randomized bench with accelerator stand-in and queue-level scheduler model
module tb_fact_scheduler;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   cmp_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fact_scheduler_if bus();

  fact_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * i;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Accelerator stand-in: done is reported from the cfg_k-th status poll after go; cfg_k=0 never finishes.
  int         cfg_k = 3;
  bit         cfg_err = 1'b0;
  logic [3:0] acc_n_q = 4'h0;
  int         acc_k_q = 0;
  logic       acc_err_q = 1'b0;
  int         acc_since_q = 0;
  logic       acc_run_q = 1'b0;
  logic       acc_done;

  always @(posedge clk) begin
    if (bus.fa_we && bus.fa_a == 2'd0) acc_n_q <= bus.fa_wd;
    if (bus.fa_we && bus.fa_a == 2'd1 && bus.fa_wd[0]) begin
      acc_since_q <= 0;
      acc_run_q   <= 1'b1;
      acc_k_q     <= cfg_k;
      acc_err_q   <= cfg_err;
    end else if (acc_run_q) begin
      acc_since_q <= acc_since_q + 1;
    end
  end

  always_comb begin
    acc_done = acc_run_q && (acc_k_q != 0) && (acc_since_q >= acc_k_q - 1);
    case (bus.fa_a)
      2'd2:    bus.fa_rd = {30'd0, acc_done && acc_err_q, acc_done};
      2'd3:    bus.fa_rd = fact(acc_n_q);
      default: bus.fa_rd = 32'h0;
    endcase
  end

  // Scheduler model: job/result queues plus an age counter for the job in flight
  // (age 0 load, 1 go, 2..W+1 polling, W+2 capture).
  int          mq_job[$];
  logic [32:0] mq_res[$];
  bit          m_ovf = 1'b0;
  bit          m_inflight = 1'b0;
  int          m_age = 0;
  int          m_w = 1;
  bit          m_err = 1'b0;
  logic [3:0]  m_n = 4'h0;

  always @(posedge clk) begin : model
    bit wr_job, wr_res, wr_ctrl, do_flush;
    int jn, rn;
    wr_job   = bus.we && bus.a == 2'd0;
    wr_res   = bus.we && bus.a == 2'd1;
    wr_ctrl  = bus.we && bus.a == 2'd3;
    do_flush = wr_ctrl && bus.wd[1];
    if (!rst) begin
      mq_job.delete();
      mq_res.delete();
      m_ovf = 1'b0;
      m_inflight = 1'b0;
    end else begin
      if (wr_ctrl && bus.wd[0]) m_ovf = 1'b0;
      if (do_flush) begin
        mq_job.delete();
        mq_res.delete();
        m_inflight = 1'b0;
      end else begin
        jn = mq_job.size();
        rn = mq_res.size();
        if (m_inflight) begin
          if (m_age == m_w + 2) begin
            mq_res.push_back({m_err, m_err ? 32'h0 : fact(m_n)});
            m_inflight = 1'b0;
          end else begin
            if (m_age == 0) m_n = 4'(mq_job.pop_front());
            if (m_age == 1) begin
              if (cfg_k != 0 && cfg_k <= TIMEOUT) begin
                m_w = cfg_k;
                m_err = cfg_err;
              end else begin
                m_w = TIMEOUT;
                m_err = 1'b1;
              end
            end
            m_age++;
          end
        end else if (jn > 0 && rn < DEPTH) begin
          m_inflight = 1'b1;
          m_age = 0;
        end
        if (wr_res && rn > 0) void'(mq_res.pop_front());
        if (wr_job) begin
          if (jn < DEPTH) mq_job.push_back(int'(bus.wd[3:0]));
          else m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic        e_we;
    logic [1:0]  e_a;
    logic [3:0]  e_wd;
    logic [31:0] e_rd;
    if (cmp_en) begin
      e_we = 1'b0; e_a = 2'd0; e_wd = 4'h0;
      if (m_inflight) begin
        if (m_age == 0) begin e_we = 1'b1; e_a = 2'd0; e_wd = 4'(mq_job[0]); end
        else if (m_age == 1) begin e_we = 1'b1; e_a = 2'd1; e_wd = 4'h1; end
        else if (m_age <= m_w + 1) e_a = 2'd2;
        else e_a = 2'd3;
      end
      case (bus.a)
        2'd0: e_rd = 32'(mq_job.size());
        2'd1: e_rd = (mq_res.size() > 0) ? mq_res[0][31:0] : 32'h0;
        2'd2: e_rd = {20'd0, 4'(mq_res.size()), 4'(mq_job.size()), mq_res.size() == 0,
                      mq_res.size() > 0 && mq_res[0][32], m_ovf, m_inflight};
        default: e_rd = 32'h0;
      endcase
      check("cyc_fa_we", 32'(bus.fa_we), 32'(e_we));
      check("cyc_fa_a", 32'(bus.fa_a), 32'(e_a));
      check("cyc_fa_wd", 32'(bus.fa_wd), 32'(e_wd));
      check("cyc_rd", bus.rd, e_rd);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.a = a; bus.wd = d;
    tick();
    bus.we = 1'b0; bus.a = 2'd2; bus.wd = 32'h0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    bus.a = a;
    #1;
    v = bus.rd;
    bus.a = 2'd2;
  endtask

  task automatic wait_res(input int target, input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (int'(bus.rd[11:8]) == target) begin
        lat = i;
        return;
      end
    end
  endtask

  logic [31:0] v;
  int          lat;

  initial begin
    bus.we = 1'b0; bus.a = 2'd2; bus.wd = 32'h0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("reset_status", bus.rd, 32'h8);
    check("reset_fa_we", 32'(bus.fa_we), 32'h0);
    rst = 1'b1;
    tick();

    cfg_k = 3; cfg_err = 1'b0;
    wr(2'd0, 32'd5);
    wait_res(1, 100, lat);
    check("single_latency", 32'(lat), 32'd7);
    peek(2'd1, v); check("single_res", v, 32'd120);
    peek(2'd2, v); check("single_herr", 32'(v[2]), 32'd0);
    wr(2'd1, 32'd0);
    peek(2'd2, v); check("single_empty", 32'(v[3]), 32'd1);

    cfg_k = 2; cfg_err = 1'b1;
    wr(2'd0, 32'd13);
    wait_res(1, 100, lat);
    check("err_latency", 32'(lat), 32'd6);
    peek(2'd2, v); check("err_herr", 32'(v[2]), 32'd1);
    peek(2'd1, v); check("err_res", v, 32'd0);
    wr(2'd1, 32'd0);

    cfg_k = 0; cfg_err = 1'b0;
    wr(2'd0, 32'd7);
    wait_res(1, 200, lat);
    check("timeout_latency", 32'(lat), 32'd68);
    peek(2'd2, v); check("timeout_herr", 32'(v[2]), 32'd1);
    peek(2'd1, v); check("timeout_res", v, 32'd0);
    wr(2'd1, 32'd0);

    for (int j = 1; j <= 6; j++) wr(2'd0, 32'(j));
    peek(2'd0, v); check("fill_job_count", v, 32'd4);
    peek(2'd2, v); check("fill_ovf", 32'(v[1]), 32'd1);
    wr(2'd3, 32'd1);
    peek(2'd2, v); check("ovf_cleared", 32'(v[1]), 32'd0);
    wr(2'd3, 32'd2);
    peek(2'd2, v); check("flush_status", v, 32'h8);
    tick(80);
    peek(2'd2, v); check("flush_no_late", v, 32'h8);

    cfg_k = 1;
    for (int j = 2; j <= 5; j++) wr(2'd0, 32'(j));
    wait_res(4, 200, lat);
    check("bp_filled", 32'(lat > 0), 32'd1);
    wr(2'd0, 32'd6);
    tick(5);
    peek(2'd2, v); check("bp_stalled", v, 32'h410);
    wr(2'd0, 32'd7); wr(2'd0, 32'd8); wr(2'd0, 32'd9);
    wr(2'd1, 32'd0);
    tick();
    check("bp_load_we", 32'(bus.fa_we), 32'd1);
    check("bp_load_wd", 32'(bus.fa_wd), 32'd6);
    wr(2'd0, 32'd10);
    peek(2'd2, v);
    check("load_push_full_jobs", 32'(v[7:4]), 32'd3);
    check("load_push_full_ovf", 32'(v[1]), 32'd1);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.fa_a == 2'd3) begin lat = i; break; end
      tick();
    end
    check("capt_reached", 32'(lat >= 0), 32'd1);
    wr(2'd1, 32'd0);
    peek(2'd2, v); check("capt_pop_count", 32'(v[11:8]), 32'd3);
    peek(2'd1, v); check("capt_pop_head", v, 32'd24);
    wr(2'd3, 32'd3);

    cfg_k = 0;
    wr(2'd0, 32'd4);
    tick(10);
    rst = 1'b0;
    tick();
    peek(2'd2, v); check("rst_mid_status", v, 32'h8);
    check("rst_mid_fa_we", 32'(bus.fa_we), 32'd0);
    rst = 1'b1;
    tick(70);
    peek(2'd2, v); check("rst_no_late", v, 32'h8);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 9))
          0:       cfg_k = 0;
          1:       cfg_k = TIMEOUT;
          2:       cfg_k = TIMEOUT + 1;
          default: cfg_k = $urandom_range(1, 6);
        endcase
        cfg_err = ($urandom_range(0, 3) == 0);
      end
      rst = !($urandom_range(0, 499) == 0);
      bus.we = ($urandom_range(0, 99) < 30);
      bus.a  = 2'($urandom_range(0, 3));
      bus.wd = $urandom;
      if (bus.a == 2'd3 && $urandom_range(0, 7) != 0) bus.wd[1] = 1'b0;
      tick();
    end

    rst = 1'b1; bus.we = 1'b0; bus.a = 2'd2;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
